// File: rtl/bp_be_issue_scoreboard_mw.sv
// Multi-issue hazard detector and register scoreboard.
// Decides per cycle which prefix of an in-order issue group may dispatch. The decision looks at
// RAW/WAW hazards against pending writes and within the group, at memory credits, and at
// serialising ops. It also holds the scoreboard and the credit count, and keeps a stall counter.
module bp_be_issue_scoreboard_mw #(
    parameter int unsigned issue_width_p    = 2,
    parameter int unsigned wb_ports_p       = 2,
    parameter int unsigned reg_addr_width_p = 5,
    parameter int unsigned credits_p        = 4,
    localparam int unsigned rf_els_lp       = 2 ** reg_addr_width_p,
    localparam int unsigned cnt_width_lp    = $clog2(credits_p + 1)
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,
    input  logic [issue_width_p-1:0]                 iss_v_i,
    input  logic [issue_width_p-1:0]                 iss_rs1_v_i,
    input  logic [issue_width_p*reg_addr_width_p-1:0] iss_rs1_addr_i,
    input  logic [issue_width_p-1:0]                 iss_rs2_v_i,
    input  logic [issue_width_p*reg_addr_width_p-1:0] iss_rs2_addr_i,
    input  logic [issue_width_p-1:0]                 iss_rd_w_v_i,
    input  logic [issue_width_p*reg_addr_width_p-1:0] iss_rd_addr_i,
    input  logic [issue_width_p-1:0]                 iss_mem_v_i,
    input  logic [issue_width_p-1:0]                 iss_serial_v_i,
    input  logic [wb_ports_p-1:0]                    wb_v_i,
    input  logic [wb_ports_p*reg_addr_width_p-1:0]   wb_rd_addr_i,
    input  logic                                     mem_ret_v_i,
    input  logic                                     flush_i,
    input  logic                                     debug_mode_i,
    input  logic                                     single_step_i,
    output logic [issue_width_p-1:0]                 dispatch_v_o,
    output logic [rf_els_lp-1:0]                     scoreboard_o,
    output logic                                     credits_empty_o,
    output logic                                     credits_full_o,
    output logic [15:0]                              stall_cnt_o,
    output logic                                     credit_err_o
);

    localparam int unsigned W = reg_addr_width_p;

    logic [rf_els_lp-1:0]     sb_q, sb_d;
    logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
    logic [15:0]              stall_q, stall_d;
    logic                     err_q, err_d;
    logic [issue_width_p-1:0] ok;
    logic [issue_width_p-1:0] disp;

    // Per-slot legality from current state only; same-cycle writebacks/returns are not bypassed.
    always_comb begin : hazard_check
        logic [W-1:0] rs1, rs2, rd, rd_j;
        int unsigned  mem_before;
        ok = '0;
        for (int k = 0; k < int'(issue_width_p); k++) begin
            rs1        = iss_rs1_addr_i[k*W +: W];
            rs2        = iss_rs2_addr_i[k*W +: W];
            rd         = iss_rd_addr_i[k*W +: W];
            mem_before = 0;
            ok[k]      = iss_v_i[k];
            if (iss_rs1_v_i[k] && sb_q[rs1]) ok[k] = 1'b0;
            if (iss_rs2_v_i[k] && sb_q[rs2]) ok[k] = 1'b0;
            if (iss_rd_w_v_i[k] && (rd != '0) && sb_q[rd]) ok[k] = 1'b0;
            for (int j = 0; j < k; j++) begin
                rd_j = iss_rd_addr_i[j*W +: W];
                if (iss_rd_w_v_i[j] && (rd_j != '0)) begin
                    if (iss_rs1_v_i[k] && (rs1 == rd_j)) ok[k] = 1'b0;
                    if (iss_rs2_v_i[k] && (rs2 == rd_j)) ok[k] = 1'b0;
                    if (iss_rd_w_v_i[k] && (rd == rd_j)) ok[k] = 1'b0;
                end
                if (iss_serial_v_i[j]) ok[k] = 1'b0;
                mem_before = mem_before + 32'(iss_mem_v_i[j]);
            end
            if (iss_mem_v_i[k] && (32'(cnt_q) + mem_before + 32'd1 > credits_p)) ok[k] = 1'b0;
            // Serialising ops need a fully drained pipe and must lead the group.
            if (iss_serial_v_i[k] && ((k != 0) || (sb_q != '0) || (cnt_q != '0))) ok[k] = 1'b0;
        end
    end

    // Prefix-contiguous dispatch with global gates; nothing leaves while in reset.
    always_comb begin : dispatch_mask
        disp    = '0;
        disp[0] = ok[0];
        for (int k = 1; k < int'(issue_width_p); k++) begin
            disp[k] = ok[k] & disp[k-1] & ~single_step_i;
        end
        if (flush_i || debug_mode_i || !reset_n_i) disp = '0;
    end

    // Next-state for scoreboard, credits, stall counter and error flag.
    always_comb begin : next_state
        logic [W-1:0] a;
        int unsigned  mem_disp;
        int unsigned  cnt_tmp;
        sb_d     = sb_q;
        err_d    = err_q;
        mem_disp = 0;
        for (int p = 0; p < int'(wb_ports_p); p++) begin
            a = wb_rd_addr_i[p*W +: W];
            if (wb_v_i[p]) sb_d[a] = 1'b0;
        end
        // Sets after clears so a same-cycle dispatch wins over a writeback.
        for (int k = 0; k < int'(issue_width_p); k++) begin
            a = iss_rd_addr_i[k*W +: W];
            if (disp[k] && iss_rd_w_v_i[k] && (a != '0)) sb_d[a] = 1'b1;
            mem_disp = mem_disp + 32'(disp[k] & iss_mem_v_i[k]);
        end
        sb_d[0] = 1'b0;
        if (flush_i) sb_d = '0;

        if (mem_ret_v_i && (cnt_q == '0) && (mem_disp == 0)) begin
            cnt_tmp = 0;
            err_d   = 1'b1;
        end else begin
            cnt_tmp = 32'(cnt_q) + mem_disp - 32'(mem_ret_v_i);
        end
        cnt_d = cnt_width_lp'(cnt_tmp);

        stall_d = stall_q;
        if (iss_v_i[0] && !disp[0] && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sb_q    <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign dispatch_v_o    = disp;
    assign scoreboard_o    = sb_q;
    assign credits_empty_o = (cnt_q == '0);
    assign credits_full_o  = (cnt_q == cnt_width_lp'(credits_p));
    assign stall_cnt_o     = stall_q;
    assign credit_err_o    = err_q;

endmodule

// File: tb/tb_bp_be_issue_scoreboard_mw.sv
// Scenario bench for bp_be_issue_scoreboard_mw: expected dispatch masks are queued at stimulus
// time and popped when the combinational output settles; state outputs are checked after edges.
module tb_bp_be_issue_scoreboard_mw;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  iss_v, rs1v, rs2v, rdv, memv, serv, wb_v;
    logic [9:0]  rs1a, rs2a, rda, wb_a;
    logic        mem_ret, flush, debug, sstep;
    logic [1:0]  disp;
    logic [31:0] sb;
    logic        empty, full, err;
    logic [15:0] stall;

    int          checks = 0;
    int          failures = 0;
    int          exp_stall = 0;
    int          exp_cnt = 0;
    logic [1:0]  exp_q[$];
    logic [1:0]  exp;

    always #5 clk = ~clk;

    bp_be_issue_scoreboard_mw dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .iss_v_i(iss_v), .iss_rs1_v_i(rs1v), .iss_rs1_addr_i(rs1a),
        .iss_rs2_v_i(rs2v), .iss_rs2_addr_i(rs2a),
        .iss_rd_w_v_i(rdv), .iss_rd_addr_i(rda),
        .iss_mem_v_i(memv), .iss_serial_v_i(serv),
        .wb_v_i(wb_v), .wb_rd_addr_i(wb_a),
        .mem_ret_v_i(mem_ret), .flush_i(flush), .debug_mode_i(debug), .single_step_i(sstep),
        .dispatch_v_o(disp), .scoreboard_o(sb),
        .credits_empty_o(empty), .credits_full_o(full),
        .stall_cnt_o(stall), .credit_err_o(err)
    );

    task automatic clear_in();
        iss_v = '0; rs1v = '0; rs2v = '0; rdv = '0; memv = '0; serv = '0; wb_v = '0;
        rs1a = '0; rs2a = '0; rda = '0; wb_a = '0;
        mem_ret = 1'b0; flush = 1'b0; debug = 1'b0; sstep = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic r1v, input logic [4:0] r1,
                            input logic r2v, input logic [4:0] r2, input logic wv,
                            input logic [4:0] rd, input logic m, input logic s);
        iss_v[k] = 1'b1; rs1v[k] = r1v; rs2v[k] = r2v; rdv[k] = wv; memv[k] = m; serv[k] = s;
        rs1a[k*5 +: 5] = r1; rs2a[k*5 +: 5] = r2; rda[k*5 +: 5] = rd;
    endtask

    task automatic set_wb(input int p, input logic [4:0] a);
        wb_v[p] = 1'b1; wb_a[p*5 +: 5] = a;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
        set_slot(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0);
        exp_q.push_back(2'b00);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL rst_disp got=%b exp=%b", disp, exp); end
        checks++;
        if (sb !== 32'h0) begin failures++; $display("FAIL rst_sb got=%h exp=0", sb); end
        checks++;
        if (stall !== 16'd0 || err !== 1'b0) begin
            failures++; $display("FAIL rst_stall_err got=%0d/%b exp=0/0", stall, err);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++; $display("FAIL rst_credits got=%b%b exp=10", empty, full);
        end
        @(negedge clk);
        clear_in();
        reset_n = 1'b1;
    endtask

    task automatic test_independent();
        @(negedge clk); clear_in();
        set_slot(0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
        set_slot(1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0);
        exp_q.push_back(2'b11);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL indep_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h6) begin failures++; $display("FAIL indep_sb got=%h exp=6", sb); end
        @(negedge clk); clear_in(); set_wb(0, 5'd1); set_wb(1, 5'd2);
        @(posedge clk); #1; checks++;
        if (sb !== 32'h0) begin failures++; $display("FAIL indep_wb_sb got=%h exp=0", sb); end
        // x0 is neither a hazard nor ever marked pending
        @(negedge clk); clear_in();
        set_slot(0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        set_slot(1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        exp_q.push_back(2'b11);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL x0_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h0) begin failures++; $display("FAIL x0_sb got=%h exp=0", sb); end
    endtask

    task automatic test_raw();
        @(negedge clk); clear_in();
        set_slot(0, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
        set_slot(1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL raw_grp_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h20) begin failures++; $display("FAIL raw_grp_sb got=%h exp=20", sb); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clear_in();
            set_slot(0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
            if (c == 1) set_wb(0, 5'd5);
            exp_q.push_back(c < 2 ? 2'b00 : 2'b01);
            if (c < 2) exp_stall++;
            #1; exp = exp_q.pop_front(); checks++;
            if (disp !== exp) begin
                failures++; $display("FAIL raw_wait%0d_disp got=%b exp=%b", c, disp, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sb !== 32'h100) begin failures++; $display("FAIL raw_after_sb got=%h exp=100", sb); end
        checks++;
        if (stall !== 16'(exp_stall)) begin
            failures++; $display("FAIL raw_stall got=%0d exp=%0d", stall, exp_stall);
        end
        // Intra-group WAW on x9
        @(negedge clk); clear_in(); set_wb(0, 5'd8);
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        set_slot(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL waw_grp_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h200) begin failures++; $display("FAIL waw_grp_sb got=%h exp=200", sb); end
        // RAW through rs2 against pending x9
        @(negedge clk); clear_in();
        set_slot(0, 1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd11, 1'b0, 1'b0);
        exp_q.push_back(2'b00); exp_stall++;
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL raw_rs2_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1;
        // WAW against pending x9 while its writeback is in flight
        @(negedge clk); clear_in(); set_wb(1, 5'd9);
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        exp_q.push_back(2'b00); exp_stall++;
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL waw_sb_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h0) begin failures++; $display("FAIL waw_sb_sb got=%h exp=0", sb); end
    endtask

    task automatic test_credits();
        logic [1:0] pat_mem[8];
        logic [1:0] pat_exp[8];
        logic       pat_ret[8];
        pat_mem = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
        pat_exp = '{2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        pat_ret = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); clear_in();
            if (pat_mem[c][0]) set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
            if (pat_mem[c][1]) set_slot(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
            mem_ret = pat_ret[c];
            exp_q.push_back(pat_exp[c]);
            if (pat_mem[c][0] && !pat_exp[c][0]) exp_stall++;
            exp_cnt = exp_cnt + int'(pat_exp[c][0]) + int'(pat_exp[c][1]) - int'(pat_ret[c]);
            #1; exp = exp_q.pop_front(); checks++;
            if (disp !== exp) begin
                failures++; $display("FAIL cred%0d_disp got=%b exp=%b", c, disp, exp);
            end
            @(posedge clk); #1; checks++;
            if (exp_cnt > 4 || exp_cnt < 0 || full !== (exp_cnt == 4) || empty !== (exp_cnt == 0))
            begin
                failures++;
                $display("FAIL cred%0d_count full/empty got=%b/%b model_cnt=%0d", c, full, empty,
                         exp_cnt);
            end
        end
        checks++;
        if (err !== 1'b0 || stall !== 16'(exp_stall)) begin
            failures++; $display("FAIL cred_err_stall got=%b/%0d exp=0/%0d", err, stall, exp_stall);
        end
    endtask

    task automatic test_serial();
        @(negedge clk); clear_in();
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL ser_set_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); clear_in();
            set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            set_slot(1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 1'b0);
            if (c == 1) set_wb(0, 5'd7);
            exp_q.push_back(c < 2 ? 2'b00 : 2'b01);
            if (c < 2) exp_stall++;
            #1; exp = exp_q.pop_front(); checks++;
            if (disp !== exp) begin
                failures++; $display("FAIL ser%0d_disp got=%b exp=%b", c, disp, exp);
            end
            @(posedge clk); #1; checks++;
            if (stall !== 16'(exp_stall)) begin
                failures++; $display("FAIL ser%0d_stall got=%0d exp=%0d", c, stall, exp_stall);
            end
        end
        checks++;
        if (sb !== 32'h0) begin failures++; $display("FAIL ser_sb got=%h exp=0", sb); end
        // A serialising op outside slot 0 never goes
        @(negedge clk); clear_in();
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd13, 1'b0, 1'b0);
        set_slot(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL ser_s1_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1;
        @(negedge clk); clear_in(); set_wb(1, 5'd13);
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        @(negedge clk); clear_in();
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL fl_pre_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h10) begin failures++; $display("FAIL fl_pre_sb got=%h exp=10", sb); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); clear_in();
            set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
            if (c == 0) flush = 1'b1; else debug = 1'b1;
            exp_q.push_back(2'b00); exp_stall++;
            #1; exp = exp_q.pop_front(); checks++;
            if (disp !== exp) begin
                failures++; $display("FAIL fl%0d_disp got=%b exp=%b", c, disp, exp);
            end
            @(posedge clk); #1; checks++;
            if (sb !== 32'h0 || empty !== 1'b0 || stall !== 16'(exp_stall)) begin
                failures++;
                $display("FAIL fl%0d_state sb=%h empty=%b stall=%0d exp sb=0 empty=0 stall=%0d",
                         c, sb, empty, stall, exp_stall);
            end
        end
        @(negedge clk); clear_in(); mem_ret = 1'b1;
        @(posedge clk); #1; checks++;
        if (empty !== 1'b1 || err !== 1'b0) begin
            failures++; $display("FAIL fl_ret_ok got=%b/%b exp=1/0", empty, err);
        end
        @(negedge clk); clear_in(); mem_ret = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); clear_in();
        @(posedge clk); #1; checks++;
        if (err !== 1'b1 || empty !== 1'b1) begin
            failures++; $display("FAIL fl_ret_err got=%b/%b exp=1/1", err, empty);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); clear_in();
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL rm_set_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1;
        @(negedge clk); clear_in();
        set_slot(0, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        exp_stall++;
        @(posedge clk); #1; checks++;
        if (stall !== 16'(exp_stall) || sb !== 32'h1000) begin
            failures++; $display("FAIL rm_pre got=%0d/%h exp=%0d/1000", stall, sb, exp_stall);
        end
        @(negedge clk); #2;
        reset_n = 1'b0;
        exp_q.push_back(2'b00);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp || sb !== 32'h0 || stall !== 16'd0 || err !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL rm_async got disp=%b sb=%h stall=%0d err=%b empty=%b exp 00/0/0/0/1",
                     disp, sb, stall, err, empty);
        end
        @(negedge clk); clear_in(); reset_n = 1'b1; exp_stall = 0;
        @(negedge clk); clear_in(); sstep = 1'b1;
        set_slot(0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0, 1'b0);
        set_slot(1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        #1; exp = exp_q.pop_front(); checks++;
        if (disp !== exp) begin failures++; $display("FAIL sstep_disp got=%b exp=%b", disp, exp); end
        @(posedge clk); #1; checks++;
        if (sb !== 32'h2 || stall !== 16'd0) begin
            failures++; $display("FAIL sstep_state got=%h/%0d exp=2/0", sb, stall);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw();
        test_credits();
        test_serial();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
